// File: rtl/rv32i_control_fsm_if.sv
// Bundle of opcode/handshake inputs and strobe/status outputs exchanged
// between the multi-cycle RV32I control unit and the rest of the datapath.
interface rv32i_control_fsm_if #(
  parameter int unsigned INSTRET_W = 32
);
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 mem_ready;
  logic [2:0]           control_unit_state;
  logic                 ir_we;
  logic                 oldpc_we;
  logic                 pc_we;
  logic                 pc_lsb_clr;
  logic                 rf_we;
  logic [1:0]           wb_sel;
  logic                 mem_req;
  logic                 mem_we;
  logic                 mem_is_instr;
  logic                 illegal;
  logic                 bus_error;
  logic                 halted;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output control_unit_state, ir_we, oldpc_we, pc_we, pc_lsb_clr, rf_we,
           wb_sel, mem_req, mem_we, mem_is_instr, illegal, bus_error,
           halted, instret
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  control_unit_state, ir_we, oldpc_we, pc_we, pc_lsb_clr, rf_we,
           wb_sel, mem_req, mem_we, mem_is_instr, illegal, bus_error,
           halted, instret
  );
endinterface

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch, decode, execute, memory
// and writeback, raises datapath strobes, counts retired instructions and
// halts on illegal opcodes or memory accesses that never complete.
module rv32i_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input logic                 clk,
  input logic                 rst,
  rv32i_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    FETCH_S1     = 3'd0,
    DECODE_S2    = 3'd1,
    EXECUTE_S3   = 3'd2,
    MEMORY_S4    = 3'd3,
    WRITEBACK_S5 = 3'd4,
    TRAP_S6      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t               state, state_next;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [31:0]          wait_ext;
  logic                 wait_limit;
  logic                 retire;
  logic                 illegal_set;
  logic                 bus_err_set;
  logic                 illegal_q;
  logic                 bus_error_q;
  logic [INSTRET_W-1:0] instret_q;

  logic                 ir_we, oldpc_we, pc_we, pc_lsb_clr, rf_we;
  logic [1:0]           wb_sel;
  logic                 mem_req, mem_we, mem_is_instr;

  // A stalled access times out when this cycle would be the MEM_TIMEOUT-th
  // consecutive wait; a zero limit disables the check entirely.
  assign wait_ext   = 32'(wait_cnt);
  assign wait_limit = (MEM_TIMEOUT != 0) && ((wait_ext + 32'd1) == MEM_TIMEOUT);

  // Next state and strobes; reset forces every strobe low and steers to fetch.
  always_comb begin
    state_next   = state;
    ir_we        = 1'b0;
    oldpc_we     = 1'b0;
    pc_we        = 1'b0;
    pc_lsb_clr   = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_instr = 1'b0;
    retire       = 1'b0;
    illegal_set  = 1'b0;
    bus_err_set  = 1'b0;
    if (rst) begin
      state_next = FETCH_S1;
    end else begin
      case (state)
        FETCH_S1: begin
          mem_req      = 1'b1;
          mem_is_instr = 1'b1;
          if (bus.mem_ready) begin
            ir_we      = 1'b1;
            oldpc_we   = 1'b1;
            pc_we      = 1'b1;
            state_next = DECODE_S2;
          end else if (wait_limit) begin
            bus_err_set = 1'b1;
            state_next  = TRAP_S6;
          end
        end
        DECODE_S2: begin
          case (bus.opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_next = EXECUTE_S3;
            default: begin
              illegal_set = 1'b1;
              state_next  = TRAP_S6;
            end
          endcase
        end
        EXECUTE_S3: begin
          case (bus.opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: state_next = WRITEBACK_S5;
            OP_LOAD, OP_STORE:            state_next = MEMORY_S4;
            OP_BRANCH: begin
              pc_we      = bus.branch_taken;
              retire     = 1'b1;
              state_next = FETCH_S1;
            end
            OP_JAL, OP_JALR: begin
              rf_we      = 1'b1;
              wb_sel     = 2'd2;
              pc_we      = 1'b1;
              pc_lsb_clr = (bus.opcode == OP_JALR);
              retire     = 1'b1;
              state_next = FETCH_S1;
            end
            default: begin
              illegal_set = 1'b1;
              state_next  = TRAP_S6;
            end
          endcase
        end
        MEMORY_S4: begin
          mem_req = 1'b1;
          mem_we  = (bus.opcode == OP_STORE);
          if (bus.mem_ready) begin
            if (bus.opcode == OP_STORE) begin
              retire     = 1'b1;
              state_next = FETCH_S1;
            end else begin
              state_next = WRITEBACK_S5;
            end
          end else if (wait_limit) begin
            bus_err_set = 1'b1;
            state_next  = TRAP_S6;
          end
        end
        WRITEBACK_S5: begin
          rf_we      = 1'b1;
          wb_sel     = (bus.opcode == OP_LOAD) ? 2'd1 : 2'd0;
          retire     = 1'b1;
          state_next = FETCH_S1;
        end
        TRAP_S6: state_next = TRAP_S6;
        default: state_next = FETCH_S1;
      endcase
    end
  end

  // State register, sticky error flags and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_S1;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      instret_q   <= '0;
    end else begin
      state <= state_next;
      if (illegal_set) illegal_q <= 1'b1;
      if (bus_err_set) bus_error_q <= 1'b1;
      if (retire) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  // Counts consecutive stalled cycles of one access; any progress or state
  // change starts the count over.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state_next != state) || bus.mem_ready || !mem_req) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.control_unit_state = state;
  assign bus.ir_we              = ir_we;
  assign bus.oldpc_we           = oldpc_we;
  assign bus.pc_we              = pc_we;
  assign bus.pc_lsb_clr         = pc_lsb_clr;
  assign bus.rf_we              = rf_we;
  assign bus.wb_sel             = wb_sel;
  assign bus.mem_req            = mem_req;
  assign bus.mem_we             = mem_we;
  assign bus.mem_is_instr       = mem_is_instr;
  assign bus.illegal            = illegal_q;
  assign bus.bus_error          = bus_error_q;
  assign bus.halted             = (state == TRAP_S6);
  assign bus.instret            = instret_q;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Directed bench for the RV32I control FSM. The DUT is built with a short
// memory timeout and a narrow retire counter so boundaries are reachable.
module tb_rv32i_control_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // {state[2:0], ir_we, oldpc_we, pc_we, pc_lsb_clr, rf_we, wb_sel[1:0], mem_req, mem_we, mem_is_instr}
  localparam logic [12:0] F_WAIT  = 13'b000_0_0_0_0_0_00_1_0_1;
  localparam logic [12:0] F_DONE  = 13'b000_1_1_1_0_0_00_1_0_1;
  localparam logic [12:0] DEC     = 13'b001_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] EX_NONE = 13'b010_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] EX_BR_T = 13'b010_0_0_1_0_0_00_0_0_0;
  localparam logic [12:0] EX_JAL  = 13'b010_0_0_1_0_1_10_0_0_0;
  localparam logic [12:0] EX_JALR = 13'b010_0_0_1_1_1_10_0_0_0;
  localparam logic [12:0] MEM_LD  = 13'b011_0_0_0_0_0_00_1_0_0;
  localparam logic [12:0] MEM_ST  = 13'b011_0_0_0_0_0_00_1_1_0;
  localparam logic [12:0] WB_ALU  = 13'b100_0_0_0_0_1_00_0_0_0;
  localparam logic [12:0] WB_LD   = 13'b100_0_0_0_0_1_01_0_0_0;
  localparam logic [12:0] TRAP    = 13'b101_0_0_0_0_0_00_0_0_0;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  int         vectors;
  int         miscompares;

  rv32i_control_fsm_if #(.INSTRET_W(3)) bus ();

  assign bus.opcode       = opcode;
  assign bus.branch_taken = branch_taken;
  assign bus.mem_ready    = mem_ready;

  rv32i_control_fsm #(.MEM_TIMEOUT(4), .INSTRET_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [12:0] obs;
  assign obs = {bus.control_unit_state, bus.ir_we, bus.oldpc_we, bus.pc_we,
                bus.pc_lsb_clr, bus.rf_we, bus.wb_sel, bus.mem_req,
                bus.mem_we, bus.mem_is_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with mem_ready high: everything clears and no strobe leaks out.
  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes: got %b want %b", obs, 13'd0);
    end
    vectors++;
    if ({bus.instret, bus.illegal, bus.bus_error, bus.halted} !== 6'b000_0_0_0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got %b want %b",
               {bus.instret, bus.illegal, bus.bus_error, bus.halted}, 6'b0);
    end
    rst = 1'b0; mem_ready = 1'b0;
  endtask

  // ADDI with fetch completing on the second cycle.
  task automatic test_addi();
    logic [12:0] exp_seq [5] = '{F_WAIT, F_DONE, DEC, EX_NONE, WB_ALU};
    logic        rdy_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    opcode = OP_I;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy_seq[i]; #1;
      vectors++;
      if (obs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL addi cyc%0d: got %b want %b", i, obs, exp_seq[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if (bus.instret !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL addi_instret: got %0d want 1", bus.instret);
    end
  endtask

  // LW with data ready after three stalls, then SW with immediate ready.
  task automatic test_load_store();
    logic [12:0] ld_exp [8] = '{F_DONE, DEC, EX_NONE, MEM_LD, MEM_LD, MEM_LD, MEM_LD, WB_LD};
    logic        ld_rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [12:0] st_exp [4] = '{F_DONE, DEC, EX_NONE, MEM_ST};
    logic        st_rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    opcode = OP_LOAD;
    for (int i = 0; i < 8; i++) begin
      mem_ready = ld_rdy[i]; #1;
      vectors++;
      if (obs !== ld_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL lw cyc%0d: got %b want %b", i, obs, ld_exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if (bus.instret !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL lw_instret: got %0d want 2", bus.instret);
    end
    opcode = OP_STORE;
    for (int i = 0; i < 4; i++) begin
      mem_ready = st_rdy[i]; #1;
      vectors++;
      if (obs !== st_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL sw cyc%0d: got %b want %b", i, obs, st_exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if ({bus.control_unit_state, bus.instret} !== {3'd0, 3'd3}) begin
      miscompares++;
      $display("[TB] FAIL sw_return: got state %0d instret %0d want 0/3",
               bus.control_unit_state, bus.instret);
    end
  endtask

  // BEQ taken then not taken; both retire straight out of execute.
  task automatic test_branch();
    logic [12:0] exp_seq [6] = '{F_DONE, DEC, EX_BR_T, F_DONE, DEC, EX_NONE};
    logic        rdy_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tkn_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    opcode = OP_BRANCH;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy_seq[i]; branch_taken = tkn_seq[i]; #1;
      vectors++;
      if (obs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL beq cyc%0d: got %b want %b", i, obs, exp_seq[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; branch_taken = 1'b0; #1;
    vectors++;
    if ({bus.control_unit_state, bus.instret} !== {3'd0, 3'd5}) begin
      miscompares++;
      $display("[TB] FAIL beq_return: got state %0d instret %0d want 0/5",
               bus.control_unit_state, bus.instret);
    end
  endtask

  // JALR then JAL: link write, PC load and LSB clear only for JALR.
  task automatic test_jumps();
    logic [12:0] exp_seq [6] = '{F_DONE, DEC, EX_JALR, F_DONE, DEC, EX_JAL};
    logic        rdy_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [6:0]  op_seq  [6] = '{OP_JALR, OP_JALR, OP_JALR, OP_JAL, OP_JAL, OP_JAL};
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy_seq[i]; opcode = op_seq[i]; #1;
      vectors++;
      if (obs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL jump cyc%0d: got %b want %b", i, obs, exp_seq[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if ({bus.control_unit_state, bus.instret} !== {3'd0, 3'd7}) begin
      miscompares++;
      $display("[TB] FAIL jump_return: got state %0d instret %0d want 0/7",
               bus.control_unit_state, bus.instret);
    end
  endtask

  // Unsupported opcode traps; mem_ready is ignored there; reset recovers.
  task automatic test_illegal();
    logic [12:0] exp_seq [5] = '{F_DONE, DEC, TRAP, TRAP, TRAP};
    logic        rdy_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    opcode = OP_BAD;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy_seq[i]; #1;
      vectors++;
      if (obs !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL illegal cyc%0d: got %b want %b", i, obs, exp_seq[i]);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if ({bus.illegal, bus.halted, bus.bus_error, bus.instret} !== {1'b1, 1'b1, 1'b0, 3'd7}) begin
      miscompares++;
      $display("[TB] FAIL illegal_flags: got ill=%b halt=%b be=%b instret=%0d want 1/1/0/7",
               bus.illegal, bus.halted, bus.bus_error, bus.instret);
    end
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({obs, bus.illegal, bus.halted} !== {13'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL illegal_recover: got %b ill=%b halt=%b want %b/0/0",
               obs, bus.illegal, bus.halted, 13'd0);
    end
    rst = 1'b0; mem_ready = 1'b0;
  endtask

  // Fetch and memory timeouts at the limit, and ready arriving just in time.
  task automatic test_timeout();
    logic [13:0] to_exp [5] = '{{F_WAIT, 1'b0}, {F_WAIT, 1'b0}, {F_WAIT, 1'b0},
                                {F_WAIT, 1'b0}, {TRAP, 1'b1}};
    logic [12:0] ok_exp [7] = '{F_WAIT, F_WAIT, F_WAIT, F_DONE, DEC, EX_NONE, WB_ALU};
    logic        ok_rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [12:0] mt_exp [8] = '{F_DONE, DEC, EX_NONE, MEM_LD, MEM_LD, MEM_LD, MEM_LD, TRAP};
    logic        mt_rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; mem_ready = 1'b0; opcode = OP_R;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({obs, bus.bus_error} !== to_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL fetch_timeout cyc%0d: got %b want %b", i, {obs, bus.bus_error}, to_exp[i]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = ok_rdy[i]; #1;
      vectors++;
      if (obs !== ok_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL ready_at_limit cyc%0d: got %b want %b", i, obs, ok_exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if ({bus.bus_error, bus.instret} !== {1'b0, 3'd1}) begin
      miscompares++;
      $display("[TB] FAIL ready_at_limit_status: got be=%b instret=%0d want 0/1",
               bus.bus_error, bus.instret);
    end
    opcode = OP_LOAD;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mt_rdy[i]; #1;
      vectors++;
      if (obs !== mt_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL mem_timeout cyc%0d: got %b want %b", i, obs, mt_exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if ({bus.bus_error, bus.halted, bus.instret} !== {1'b1, 1'b1, 3'd1}) begin
      miscompares++;
      $display("[TB] FAIL mem_timeout_status: got be=%b halt=%b instret=%0d want 1/1/1",
               bus.bus_error, bus.halted, bus.instret);
    end
  endtask

  // Eight back-to-back ADDIs walk the 3-bit retire counter through wrap.
  task automatic test_instret_wrap();
    logic [2:0] exp_cnt;
    rst = 1'b1; mem_ready = 1'b0; opcode = OP_I;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < 4; c++) begin
        mem_ready = (c == 0);
        @(negedge clk);
      end
      mem_ready = 1'b0; #1;
      exp_cnt = 3'(n + 1);
      vectors++;
      if ({bus.control_unit_state, bus.instret} !== {3'd0, exp_cnt}) begin
        miscompares++;
        $display("[TB] FAIL wrap instr%0d: got state %0d instret %0d want 0/%0d",
                 n, bus.control_unit_state, bus.instret, exp_cnt);
      end
    end
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Run every scenario in order, then report.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    opcode       = OP_R;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_load_store();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    test_instret_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
